// File: rtl/bios_boot_sequencer.sv
// Dual-flash BIOS boot sequencer: watchdog-driven flash swap, power cycle, lockout.
// Ports: LpcClock/Reset (sync, active-high); Strobe125msec, PS_ONn, BiosFinished,
//   BiosWDFire, BiosDefaultSel, ClearFail in; BiosSelect, ForcePowerOff,
//   PowerRestartReq, SwapCount[1:0], BootFailed, SeqState[2:0] out.
module bios_boot_sequencer #(
    parameter int OFF_DELAY = 8,
    parameter int MAX_SWAPS = 2
) (
    input  logic       LpcClock,
    input  logic       Reset,
    input  logic       Strobe125msec,
    input  logic       PS_ONn,
    input  logic       BiosFinished,
    input  logic       BiosWDFire,
    input  logic       BiosDefaultSel,
    input  logic       ClearFail,
    output logic       BiosSelect,
    output logic       ForcePowerOff,
    output logic       PowerRestartReq,
    output logic [1:0] SwapCount,
    output logic       BootFailed,
    output logic [2:0] SeqState
);

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_BOOT    = 3'b001;
    localparam logic [2:0] S_OFF     = 3'b010;
    localparam logic [2:0] S_RESTART = 3'b011;
    localparam logic [2:0] S_WAIT_ON = 3'b100;
    localparam logic [2:0] S_DONE    = 3'b101;
    localparam logic [2:0] S_FAILED  = 3'b110;

    localparam logic [3:0] OFF_DLY = OFF_DELAY[3:0];
    localparam logic [1:0] MAX_SW  = MAX_SWAPS[1:0];

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] r_delay;
    logic [3:0] w_delay_inc;
    logic       r_sel;
    logic       r_fpo;
    logic       r_prr;
    logic       r_bf;
    logic [1:0] r_swap;
    logic       w_off_done;
    logic       w_swap;
    logic       w_clear_swap;
    logic       w_restore_sel;

    // Leaving OFF happens on the strobe that brings the count to OFF_DELAY.
    assign w_delay_inc = r_delay + {3'b000, Strobe125msec};
    assign w_off_done  = (w_delay_inc == OFF_DLY);

    always_comb begin
        w_next        = r_state;
        w_swap        = 1'b0;
        w_clear_swap  = 1'b0;
        w_restore_sel = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!PS_ONn) w_next = S_BOOT;
            end
            S_BOOT: begin
                if (BiosFinished)    w_next = S_DONE;
                else if (BiosWDFire) w_next = S_OFF;
                else if (PS_ONn)     w_next = S_IDLE;
            end
            S_OFF: begin
                if (w_off_done) begin
                    if (r_swap == MAX_SW) begin
                        w_next = S_FAILED;
                    end else begin
                        w_next = S_RESTART;
                        w_swap = 1'b1;
                    end
                end
            end
            S_RESTART: begin
                w_next = S_WAIT_ON;
            end
            S_WAIT_ON: begin
                if (!PS_ONn) w_next = S_BOOT;
            end
            S_DONE: begin
                if (PS_ONn) begin
                    w_next       = S_IDLE;
                    w_clear_swap = 1'b1;
                end
            end
            S_FAILED: begin
                if (ClearFail) begin
                    w_next        = S_IDLE;
                    w_clear_swap  = 1'b1;
                    w_restore_sel = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge LpcClock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_delay <= 4'd0;
            r_sel   <= BiosDefaultSel;
            r_swap  <= 2'd0;
            r_fpo   <= 1'b0;
            r_prr   <= 1'b0;
            r_bf    <= 1'b0;
        end else begin
            r_state <= w_next;
            // Held at zero outside OFF, so it is always clear on entry.
            if (r_state == S_OFF) r_delay <= w_delay_inc;
            else                  r_delay <= 4'd0;
            if (w_swap) begin
                r_sel <= ~r_sel;
                if (r_swap != MAX_SW) r_swap <= r_swap + 2'd1;
            end else if (w_clear_swap) begin
                r_swap <= 2'd0;
            end
            if (w_restore_sel) r_sel <= BiosDefaultSel;
            // Decoded from next state so they track state entry exactly.
            r_fpo <= (w_next == S_OFF) || (w_next == S_FAILED);
            r_bf  <= (w_next == S_FAILED);
            r_prr <= (w_next == S_RESTART);
        end
    end

    assign BiosSelect      = r_sel;
    assign ForcePowerOff   = r_fpo;
    assign PowerRestartReq = r_prr;
    assign SwapCount       = r_swap;
    assign BootFailed      = r_bf;
    assign SeqState        = r_state;

endmodule

// File: tb/tb_bios_boot_sequencer.sv
// Testbench for bios_boot_sequencer: vector table, directed corner sequences,
// and randomized stimulus against a behavioural reference model.
module tb_bios_boot_sequencer;

    localparam int OFFD = 8;
    localparam int MAXS = 2;

    localparam int P_IDLE = 0, P_BOOT = 1, P_OFF = 2, P_RESTART = 3;
    localparam int P_WAIT = 4, P_DONE = 5, P_FAILED = 6;

    logic       clk = 1'b0;
    logic       Reset, Strobe125msec, PS_ONn, BiosFinished;
    logic       BiosWDFire, BiosDefaultSel, ClearFail;
    logic       BiosSelect, ForcePowerOff, PowerRestartReq, BootFailed;
    logic [1:0] SwapCount;
    logic [2:0] SeqState;

    bios_boot_sequencer #(.OFF_DELAY(OFFD), .MAX_SWAPS(MAXS)) dut (
        .LpcClock(clk),
        .Reset(Reset),
        .Strobe125msec(Strobe125msec),
        .PS_ONn(PS_ONn),
        .BiosFinished(BiosFinished),
        .BiosWDFire(BiosWDFire),
        .BiosDefaultSel(BiosDefaultSel),
        .ClearFail(ClearFail),
        .BiosSelect(BiosSelect),
        .ForcePowerOff(ForcePowerOff),
        .PowerRestartReq(PowerRestartReq),
        .SwapCount(SwapCount),
        .BootFailed(BootFailed),
        .SeqState(SeqState)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_prr = 0;

    // Reference model: boot phase, strobes seen while off, swaps, flash select.
    int m_ph = P_IDLE;
    int m_cnt = 0;
    int m_sw = 0;
    bit m_sel = 1'b0;

    typedef struct {
        bit rst, ps, fin, wd, stb, clr, def;
        int st;
        bit sel, fpo, prr;
        int sw;
        bit bf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, ps, fin, wd, stb, clr, def);
        if (rst) begin
            m_ph = P_IDLE; m_sel = def; m_sw = 0; m_cnt = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (!ps) m_ph = P_BOOT;
                P_BOOT: begin
                    if (fin) m_ph = P_DONE;
                    else if (wd) begin m_ph = P_OFF; m_cnt = 0; end
                    else if (ps) m_ph = P_IDLE;
                end
                P_OFF: begin
                    m_cnt = m_cnt + int'(stb);
                    if (m_cnt == OFFD) begin
                        if (m_sw == MAXS) m_ph = P_FAILED;
                        else begin
                            m_ph = P_RESTART; m_sel = !m_sel; m_sw++;
                        end
                    end
                end
                P_RESTART: m_ph = P_WAIT;
                P_WAIT: if (!ps) m_ph = P_BOOT;
                P_DONE: if (ps) begin m_ph = P_IDLE; m_sw = 0; end
                P_FAILED: if (clr) begin
                    m_ph = P_IDLE; m_sw = 0; m_sel = def;
                end
                default: m_ph = P_IDLE;
            endcase
        end
    endtask

    task automatic tick(input bit rst, ps, fin, wd, stb, clr, def);
        Reset = rst; PS_ONn = ps; BiosFinished = fin; BiosWDFire = wd;
        Strobe125msec = stb; ClearFail = clr; BiosDefaultSel = def;
        @(posedge clk);
        model_step(rst, ps, fin, wd, stb, clr, def);
        #1;
        if (PowerRestartReq) n_prr++;
        chk("m_state", int'(SeqState), m_ph);
        chk("m_sel", int'(BiosSelect), int'(m_sel));
        chk("m_swap", int'(SwapCount), m_sw);
        chk("m_fpo", int'(ForcePowerOff), int'(m_ph == P_OFF || m_ph == P_FAILED));
        chk("m_prr", int'(PowerRestartReq), int'(m_ph == P_RESTART));
        chk("m_bf", int'(BootFailed), int'(m_ph == P_FAILED));
    endtask

    // Drives three watchdog boots from IDLE; ends in lockout.
    task automatic run_lockout(input bit def);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 0, 0, 0, def);
            tick(0, 0, 0, 1, 0, 0, def);
            for (int s = 0; s < OFFD; s++) tick(0, 0, 0, 0, 1, 0, def);
            if (k < 2) tick(0, 1, 0, 0, 0, 0, def);
        end
    endtask

    initial begin
        bit ps;
        Reset = 1; PS_ONn = 1; BiosFinished = 0; BiosWDFire = 0;
        Strobe125msec = 0; ClearFail = 0; BiosDefaultSel = 0;

        //                 rst ps fin wd stb clr def  st sel fpo prr sw bf
        tbl.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0});
        for (int s = 2; s < OFFD; s++)
            tbl.push_back(vec_t'{0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 1, 1, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 0, 0, 0, 4, 1, 0, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0, 1, 0, 5, 1, 0, 0, 1, 0});
        tbl.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back(vec_t'{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].ps, tbl[i].fin, tbl[i].wd,
                 tbl[i].stb, tbl[i].clr, tbl[i].def);
            chk($sformatf("tbl%0d_state", i), int'(SeqState), tbl[i].st);
            chk($sformatf("tbl%0d_sel", i), int'(BiosSelect), int'(tbl[i].sel));
            chk($sformatf("tbl%0d_fpo", i), int'(ForcePowerOff), int'(tbl[i].fpo));
            chk($sformatf("tbl%0d_prr", i), int'(PowerRestartReq), int'(tbl[i].prr));
            chk($sformatf("tbl%0d_swap", i), int'(SwapCount), tbl[i].sw);
            chk($sformatf("tbl%0d_bf", i), int'(BootFailed), int'(tbl[i].bf));
        end

        // Lockout after three watchdog fires, then ClearFail recovery.
        tick(1, 1, 0, 0, 0, 0, 1);
        chk("lock_rst_sel", int'(BiosSelect), 1);
        n_prr = 0;
        run_lockout(1);
        chk("lock_state", int'(SeqState), 6);
        chk("lock_bf", int'(BootFailed), 1);
        chk("lock_fpo", int'(ForcePowerOff), 1);
        chk("lock_swap", int'(SwapCount), 2);
        chk("lock_prr_cnt", n_prr, 2);
        tick(0, 0, 1, 1, 1, 0, 1);
        chk("lock_ignore", int'(SeqState), 6);
        tick(0, 0, 0, 0, 0, 1, 0);
        chk("clr_state", int'(SeqState), 0);
        chk("clr_swap", int'(SwapCount), 0);
        chk("clr_sel", int'(BiosSelect), 0);
        chk("clr_bf", int'(BootFailed), 0);

        // Reset after three strobes in OFF.
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 1, 0, 0);
        chk("moff_fpo_before", int'(ForcePowerOff), 1);
        n_prr = 0;
        tick(1, 0, 0, 0, 1, 0, 0);
        chk("moff_fpo", int'(ForcePowerOff), 0);
        chk("moff_state", int'(SeqState), 0);
        chk("moff_swap", int'(SwapCount), 0);
        tick(0, 1, 0, 0, 1, 0, 0);
        chk("moff_prr_cnt", n_prr, 0);

        // Reset while locked out, then boot straight out of reset.
        run_lockout(0);
        chk("lock2_state", int'(SeqState), 6);
        tick(1, 1, 0, 0, 0, 0, 1);
        chk("rstfail_fpo", int'(ForcePowerOff), 0);
        chk("rstfail_bf", int'(BootFailed), 0);
        chk("rstfail_sel", int'(BiosSelect), 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        chk("rst_boot", int'(SeqState), 1);

        // Randomized traffic against the model.
        ps = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 15) == 0) ps = ~ps;
            tick($urandom_range(0, 299) == 0, ps,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bios_boot_sequencer.md
BIOS_BOOT_SEQUENCER -- requirements
Module: bios_boot_sequencer

Interface
REQ-001 SHALL have parameter OFF_DELAY, default 8: Strobe125msec pulses held in power-off before restart (range 1..15, so 8 = 1 s).
REQ-002 SHALL have parameter MAX_SWAPS, default 2: BIOS swaps allowed per boot attempt before lockout (range 1..3).
REQ-003 SHALL have port LpcClock, input, 1 bit: 33 MHz clock; the only clock.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Strobe125msec, input, 1 bit: single-LpcClock pulse every 125 ms.
REQ-006 SHALL have port PS_ONn, input, 1 bit: host power request, low = power on.
REQ-007 SHALL have port BiosFinished, input, 1 bit: level, BIOS completed POST.
REQ-008 SHALL have port BiosWDFire, input, 1 bit: single-cycle pulse when the BIOS watchdog expires (ForceSwap event).
REQ-009 SHALL have port BiosDefaultSel, input, 1 bit: board strap selecting the primary BIOS flash.
REQ-010 SHALL have port ClearFail, input, 1 bit: single-cycle pulse from an LPC register write that clears lockout.
REQ-011 SHALL have port BiosSelect, output, 1 bit: active BIOS flash select.
REQ-012 SHALL have port ForcePowerOff, output, 1 bit: forces platform power off.
REQ-013 SHALL have port PowerRestartReq, output, 1 bit: single-cycle request to the power sequencer to restart.
REQ-014 SHALL have port SwapCount, output, 2 bits: swaps performed in the current boot attempt.
REQ-015 SHALL have port BootFailed, output, 1 bit: lockout indication.
REQ-016 SHALL have port SeqState, output, 3 bits: state encoding, for LPC readback.

Function
REQ-017 SHALL implement the FSM with these encodings: IDLE=000, BOOT=001, OFF=010, RESTART=011, WAIT_ON=100, DONE=101, FAILED=110; any other encoding SHALL return to IDLE on the next cycle.
REQ-018 IDLE: SHALL go to BOOT on the first cycle PS_ONn=0.
REQ-019 BOOT: BiosFinished=1 -> DONE; otherwise BiosWDFire=1 -> OFF; otherwise PS_ONn=1 -> IDLE. These are in priority order, so Finished beats WDFire in the same cycle.
REQ-020 OFF: ForcePowerOff=1. A 4-bit delay counter SHALL be cleared on entry and SHALL increment on each Strobe125msec.
REQ-021 OFF: when the counter reaches OFF_DELAY, the next state SHALL depend on SwapCount:
  - SwapCount==MAX_SWAPS -> FAILED.
  - Otherwise -> RESTART, with BiosSelect toggled and SwapCount incremented in the same cycle.
REQ-022 OFF: PS_ONn, BiosWDFire and BiosFinished SHALL be ignored.
REQ-023 RESTART: PowerRestartReq=1 for exactly one cycle, ForcePowerOff=0, then -> WAIT_ON.
REQ-024 WAIT_ON: PS_ONn=0 -> BOOT. BiosWDFire and BiosFinished SHALL be ignored.
REQ-025 DONE: PS_ONn=1 -> IDLE, and SwapCount SHALL be cleared on this transition. BiosSelect SHALL be retained, so the next boot uses the last good flash.
REQ-026 FAILED: ForcePowerOff=1 and BootFailed=1; all inputs except ClearFail and Reset SHALL be ignored.
REQ-027 ClearFail:
  - In FAILED -> IDLE next cycle, with SwapCount=0 and BiosSelect=BiosDefaultSel.
  - In any other state it SHALL be ignored.
REQ-028 Output timing:
  - ForcePowerOff and BootFailed SHALL be registered and decoded from the next state, so they assert on the same edge that state is entered.
  - PowerRestartReq SHALL assert on the edge RESTART is entered.
REQ-029 SwapCount SHALL saturate at MAX_SWAPS and SHALL never wrap.
REQ-030 SeqState SHALL equal the current state register.

Reset
REQ-031 While Reset=1 at a clock edge, the block SHALL set: state=IDLE, BiosSelect=BiosDefaultSel, ForcePowerOff=0, PowerRestartReq=0, SwapCount=0, BootFailed=0, delay counter=0.
REQ-032 Reset asserted mid-operation, including in OFF or FAILED, SHALL abort the sequence and deassert ForcePowerOff on the next edge; lockout SHALL NOT survive Reset.
REQ-033 Outputs SHALL hold their reset values for one cycle after Reset deasserts, unless PS_ONn=0, in which case BOOT SHALL be entered on that cycle.

Verification
REQ-034 Normal boot: BiosDefaultSel=0, PS_ONn=0, then BiosFinished=1 -> state 001 then 101; BiosSelect=0, SwapCount=0, ForcePowerOff never asserted.
REQ-035 Single swap: in BOOT, pulse BiosWDFire, then give 8 strobes -> ForcePowerOff=1 for the 8 strobes; on the 8th strobe BiosSelect=1, SwapCount=1; PowerRestartReq high for 1 cycle; then PS_ONn=0 -> BOOT.
REQ-036 Lockout: with MAX_SWAPS=2, fire the watchdog 3 times -> after the 3rd OFF_DELAY the state is 110, BootFailed=1, ForcePowerOff=1, SwapCount=2, no third PowerRestartReq; then ClearFail pulse -> IDLE, SwapCount=0, BiosSelect=BiosDefaultSel.
REQ-037 Simultaneous events: BiosFinished and BiosWDFire high in the same BOOT cycle -> DONE, no power-off.
REQ-038 Reset mid-OFF: assert Reset after 3 strobes in OFF -> next edge ForcePowerOff=0, state 000, SwapCount=0; no PowerRestartReq.
REQ-039 Power-off retention: from DONE after one swap, drive PS_ONn=1 -> IDLE, SwapCount=0, BiosSelect stays 1; ClearFail pulsed in DONE has no effect.
